nyan_song_sequencer: RTL and testbench
======================================

# nyan_song_sequencer

Beat-level scheduler for the audio voices. It counts frame ticks and fetches one pattern word per beat from the song ROM over a req/ack handshake. It then issues melody/bass/kick triggers, runs the per-tick volume and kick-pitch decay, and wraps the song position at its loop point. It sits between the video timing (frame strobe) and the oscillator/mixer datapath, which consumes its note, octave, volume and kick outputs.

## Interface
- TICKS_PER_BEAT, 6: frame ticks per beat, 2..8
- SONG_END, 287: last song position; the next position after it is LOOP_START
- LOOP_START, 32: position resumed after SONG_END
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- frame_stb  in  1  one-cycle pulse per video frame (tick)
- run  in  1  1 = sequencing enabled
- rom_req  out  1  pattern fetch request
- rom_addr  out  9  pattern address, stable while rom_req=1
- rom_ack  in  1  fetch complete; rom_data valid in the same cycle
- rom_data  in  13  {kick_trig, bass_trig, bass_oct[1:0], bass_note[2:0], mel_trig, mel_oct[1:0], mel_note[2:0]}
- songpos  out  9  current song position
- loop_count  out  2  number of SONG_END→LOOP_START wraps, modulo 4
- beat_stb  out  1  one-cycle pulse when a new pattern word is applied
- mel_note / mel_oct  out  3 / 2  current melody note and octave
- bass_note / bass_oct  out  3 / 2  current bass note and octave
- mel_vol, bass_vol  out  6 each  envelope volumes
- kick_on  out  1  kick active (kick_ctr≠0)
- kick_inc  out  9  kick oscillator phase increment
- overrun  out  1  sticky: a tick was lost

## Operation
- FSM states: IDLE, FETCH, APPLY.
- **Tick acceptance.** A tick is accepted in IDLE when frame_stb&run.
  - If tick_ctr==TICKS_PER_BEAT-1: tick_ctr←0; rom_addr←next_pos; go to FETCH.
  - next_pos = (songpos==SONG_END) ? LOOP_START : songpos+1. The 9-bit add wraps, so 0x1FF+1 = 0.
  - Otherwise: tick_ctr+1, then decay.
- **Decay** (non-beat ticks only):
  - mel_vol −= mel_vol>>3
  - bass_vol −= bass_vol>>2
  - if kick_ctr≠0: kick_ctr+1 (2-bit; wraps to 0, which ends the kick), kick_inc −= kick_inc>>3
- **FETCH.** rom_req=1 until rom_ack is sampled high; rom_data is latched on that cycle; go to APPLY.
- **APPLY.** Lasts one cycle.
  - songpos←rom_addr; note/oct fields updated.
  - mel_trig→mel_vol=63; bass_trig→bass_vol=63; kick_trig→kick_ctr=1, kick_inc=0x180.
  - If the previous songpos was SONG_END: loop_count+1.
  - beat_stb=1; return to IDLE.
- **frame_stb while not IDLE.** Sets a one-deep pending flag. The flag is serviced in IDLE on the cycle after APPLY, as if frame_stb were present. If frame_stb arrives while pending is already set, overrun←1 and the tick is dropped.
- **run=0.** New ticks are ignored and all values are held. An in-flight FETCH/APPLY completes. The pending flag is cleared.
- **Reset values:**
  - FSM=IDLE, rom_req=0, rom_addr=0
  - songpos=0x1FF, tick_ctr=TICKS_PER_BEAT-1, so the first accepted tick fetches position 0
  - loop_count=0, notes/octs=0, vols=0, kick_ctr=0, kick_inc=0
  - beat_stb=0, overrun=0, pending=0
- **Reset mid-FETCH.** rom_req drops asynchronously; a late rom_ack is ignored, since it is only honoured in FETCH.

## Timing
- Cycle 0: frame_stb sampled, beat tick. Cycle 1: rom_req=1 with valid rom_addr.
- rom_ack is sampled at cycle k≥1. Minimum k=1 (zero-wait ROM).
- Cycle k+1: APPLY; beat_stb=1 and all outputs carry new values. Minimum latency frame_stb→beat_stb is 2 cycles.
- Non-beat tick: decayed volumes are visible on cycle 1.
- All outputs are registered; no combinational path from inputs to outputs.
- A rom_ack outside FETCH has no effect.

## Configuration
- NYAN_SEQ_KICK_EN defined: the kick_ctr/kick_inc logic is built as described.
- Undefined: kick_on=0 and kick_inc=0 permanently; the kick_trig bit is ignored; the kick registers are not instantiated.

## Test plan
- Reset, run=1, zero-wait ROM, frame_stb every 20 cycles → first beat_stb 2 cycles after the first frame_stb, songpos=0; subsequent beat_stb every 6 ticks.
- Pattern at pos 0 with mel_trig=1, bass_trig=1 → mel_vol=63, bass_vol=63; after 1 non-beat tick mel_vol=56, bass_vol=48.
- kick_trig=1 (NYAN_SEQ_KICK_EN) → kick_on=1, kick_inc=0x180. Subsequent ticks give 0x150, then 0x126. kick_on=0 after the 3rd non-beat tick.
- Drive to songpos=287, next beat → songpos=32, rom_addr=32, loop_count=1.
- ROM ack delayed 40 cycles, frame_stb twice during FETCH → first tick serviced right after APPLY, second sets overrun=1.
- Assert rst_n low during FETCH, then release and issue a late rom_ack → rom_req=0, songpos=0x1FF, no beat_stb.

Source files
------------

// File: rtl/nyan_song_sequencer.sv
// Beat scheduler: frame ticks -> pattern fetch -> voice triggers and envelope decay.
// Define NYAN_SEQ_KICK_EN to build the kick pitch-sweep logic.
module nyan_song_sequencer #(
  parameter int TICKS_PER_BEAT = 6,
  parameter int SONG_END       = 287,
  parameter int LOOP_START     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_stb,
  input  logic        run,
  output logic        rom_req,
  output logic [8:0]  rom_addr,
  input  logic        rom_ack,
  input  logic [12:0] rom_data,
  output logic [8:0]  songpos,
  output logic [1:0]  loop_count,
  output logic        beat_stb,
  output logic [2:0]  mel_note,
  output logic [1:0]  mel_oct,
  output logic [2:0]  bass_note,
  output logic [1:0]  bass_oct,
  output logic [5:0]  mel_vol,
  output logic [5:0]  bass_vol,
  output logic        kick_on,
  output logic [8:0]  kick_inc,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    APPLY
  } state_t;

  localparam logic [2:0] TC_LAST = 3'(TICKS_PER_BEAT - 1);
  localparam logic [8:0] POS_END = 9'(SONG_END);
  localparam logic [8:0] POS_LOOP = 9'(LOOP_START);

  state_t     state;
  state_t     state_nx;
  logic [2:0] tick_ctr;
  logic       pending;
  logic       tick;
  logic       beat;
  logic       decay;
  logic       apply;
  logic [8:0] next_pos;

  // A pending tick is serviced exactly like a live strobe.
  assign tick  = run & (frame_stb | pending);
  assign beat  = (state == IDLE) & tick & (tick_ctr == TC_LAST);
  assign decay = (state == IDLE) & tick & (tick_ctr != TC_LAST);
  assign apply = (state == FETCH) & rom_ack;

  assign next_pos = (songpos == POS_END) ? POS_LOOP
                                         : songpos + 9'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (beat) state_nx = FETCH;
      FETCH:   if (rom_ack) state_nx = APPLY;
      APPLY:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rom_req  = (state == FETCH);
    beat_stb = (state == APPLY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_ctr   <= TC_LAST;
      rom_addr   <= '0;
      songpos    <= 9'h1ff;
      loop_count <= '0;
      mel_note   <= '0;
      mel_oct    <= '0;
      bass_note  <= '0;
      bass_oct   <= '0;
      mel_vol    <= '0;
      bass_vol   <= '0;
    end else begin
      if (beat) begin
        tick_ctr <= '0;
        rom_addr <= next_pos;
      end
      if (decay) begin
        tick_ctr <= tick_ctr + 3'd1;
        mel_vol  <= mel_vol - (mel_vol >> 3);
        bass_vol <= bass_vol - (bass_vol >> 2);
      end
      if (apply) begin
        songpos   <= rom_addr;
        mel_note  <= rom_data[2:0];
        mel_oct   <= rom_data[4:3];
        bass_note <= rom_data[8:6];
        bass_oct  <= rom_data[10:9];
        if (rom_data[5])  mel_vol  <= 6'd63;
        if (rom_data[11]) bass_vol <= 6'd63;
        if (songpos == POS_END)
          loop_count <= loop_count + 2'd1;
      end
    end
  end

  // One-deep tick buffer; a strobe that finds it full is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (!run) begin
      pending <= 1'b0;
    end else if (state != IDLE) begin
      if (frame_stb) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
    end else if (pending) begin
      pending <= frame_stb;
    end
  end

`ifdef NYAN_SEQ_KICK_EN
  logic [1:0] kick_ctr;
  logic [8:0] kick_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kick_ctr <= '0;
      kick_r   <= '0;
    end else if (decay && kick_ctr != 2'd0) begin
      kick_ctr <= kick_ctr + 2'd1;
      kick_r   <= kick_r - (kick_r >> 3);
    end else if (apply && rom_data[12]) begin
      kick_ctr <= 2'd1;
      kick_r   <= 9'h180;
    end
  end

  assign kick_on  = (kick_ctr != 2'd0);
  assign kick_inc = kick_r;
`else
  logic unused_kick;
  assign unused_kick = rom_data[12];
  assign kick_on     = 1'b0;
  assign kick_inc    = '0;
`endif

endmodule

// File: tb/tb_nyan_song_sequencer.sv
// Directed bench for nyan_song_sequencer with a delay-programmable ROM model.
// Kick expectations follow NYAN_SEQ_KICK_EN.
module tb_nyan_song_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_stb = 1'b0;
  logic        run = 1'b0;
  logic        rom_req;
  logic [8:0]  rom_addr;
  logic        rom_ack;
  logic [12:0] rom_data;
  logic [8:0]  songpos;
  logic [1:0]  loop_count;
  logic        beat_stb;
  logic [2:0]  mel_note;
  logic [1:0]  mel_oct;
  logic [2:0]  bass_note;
  logic [1:0]  bass_oct;
  logic [5:0]  mel_vol;
  logic [5:0]  bass_vol;
  logic        kick_on;
  logic [8:0]  kick_inc;
  logic        overrun;

  logic [12:0] rom [512];
  logic        model_ack = 1'b0;
  logic [12:0] model_data = '0;
  logic        man_ack = 1'b0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  assign rom_ack  = model_ack | man_ack;
  assign rom_data = man_ack ? 13'h1fff : model_data;

  nyan_song_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_stb  (frame_stb),
    .run        (run),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .songpos    (songpos),
    .loop_count (loop_count),
    .beat_stb   (beat_stb),
    .mel_note   (mel_note),
    .mel_oct    (mel_oct),
    .bass_note  (bass_note),
    .bass_oct   (bass_oct),
    .mel_vol    (mel_vol),
    .bass_vol   (bass_vol),
    .kick_on    (kick_on),
    .kick_inc   (kick_inc),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // ROM answers ack_delay negedges after it first sees rom_req.
  always @(negedge clk) begin
    if (rom_req && !model_ack) begin
      if (wait_cnt >= ack_delay) begin
        model_ack  = 1'b1;
        model_data = rom[rom_addr];
      end else begin
        wait_cnt++;
      end
    end else begin
      model_ack = 1'b0;
      wait_cnt  = 0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h",
                  tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    @(negedge clk);
    frame_stb = 1'b1;
    @(negedge clk);
    frame_stb = 1'b0;
  endtask

  task automatic do_tick();
    pulse();
    step(1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = '0;
    rom[0]  = 13'h1af5;
    rom[32] = 13'h0027;
    rom[33] = 13'h0020;

    step(2);
    chk("rst_req", 32'(rom_req), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_pos", 32'(songpos), 32'h1ff);
    chk("rst_beat", 32'(beat_stb), 32'd0);
    chk("rst_vol", 32'({mel_vol, bass_vol}), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_loop", 32'(loop_count), 32'd0);
    rst_n = 1'b1;
    run   = 1'b1;
    step(2);

    // first tick is a beat: APPLY two cycles after the strobe
    pulse();
    chk("first_req", 32'(rom_req), 32'd1);
    chk("first_addr", 32'(rom_addr), 32'd0);
    step(1);
    chk("first_beat", 32'(beat_stb), 32'd1);
    chk("first_pos", 32'(songpos), 32'd0);
    chk("apply_mvol", 32'(mel_vol), 32'd63);
    chk("apply_bvol", 32'(bass_vol), 32'd63);
    chk("apply_notes",
        32'({mel_note, mel_oct, bass_note, bass_oct}),
        32'({3'd5, 2'd2, 3'd3, 2'd1}));
`ifdef NYAN_SEQ_KICK_EN
    chk("kick_on0", 32'(kick_on), 32'd1);
    chk("kick_inc0", 32'(kick_inc), 32'h180);
`else
    chk("kick_off0", 32'({kick_on, kick_inc}), 32'd0);
`endif
    step(1);
    chk("beat_1cyc", 32'(beat_stb), 32'd0);

    // non-beat decay is visible one cycle after the strobe
    pulse();
    chk("dec1_m", 32'(mel_vol), 32'd56);
    chk("dec1_b", 32'(bass_vol), 32'd48);
`ifdef NYAN_SEQ_KICK_EN
    chk("kick_inc1", 32'(kick_inc), 32'h150);
`endif
    step(1);
    pulse();
    chk("dec2", 32'({mel_vol, bass_vol}), 32'({6'd49, 6'd36}));
`ifdef NYAN_SEQ_KICK_EN
    chk("kick_inc2", 32'(kick_inc), 32'h126);
    chk("kick_on2", 32'(kick_on), 32'd1);
`endif
    step(1);
    pulse();
    chk("dec3", 32'({mel_vol, bass_vol}), 32'({6'd43, 6'd27}));
    chk("kick_on3", 32'(kick_on), 32'd0);
    step(1);
    do_tick();
    do_tick();
    chk("no_beat5", 32'(beat_stb), 32'd0);
    chk("dec5", 32'({mel_vol, bass_vol}), 32'({6'd34, 6'd16}));
    do_tick();
    chk("beat6", 32'(beat_stb), 32'd1);
    chk("pos1", 32'(songpos), 32'd1);
    chk("hold_vol", 32'({mel_vol, bass_vol}), 32'({6'd34, 6'd16}));

    // walk to the loop point
    for (int i = 0; i < 286 * 6; i++) do_tick();
    chk("pos_end", 32'(songpos), 32'd287);
    chk("loop_pre", 32'(loop_count), 32'd0);
    for (int i = 0; i < 6; i++) do_tick();
    chk("wrap_beat", 32'(beat_stb), 32'd1);
    chk("wrap_pos", 32'(songpos), 32'd32);
    chk("wrap_addr", 32'(rom_addr), 32'd32);
    chk("wrap_loop", 32'(loop_count), 32'd1);
    chk("wrap_note", 32'({mel_note, mel_vol}), 32'({3'd7, 6'd63}));

    // slow ROM with two strobes while the fetch is outstanding
    ack_delay = 40;
    for (int i = 0; i < 5; i++) do_tick();
    pulse();
    step(3);
    pulse();
    chk("ovr_pre", 32'(overrun), 32'd0);
    step(3);
    pulse();
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("still_req", 32'(rom_req), 32'd1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (beat_stb) break;
    end
    chk("slow_beat", 32'(beat_stb), 32'd1);
    chk("slow_pos", 32'(songpos), 32'd33);
    chk("slow_vol", 32'(mel_vol), 32'd63);
    step(2);
    chk("pend_dec", 32'(mel_vol), 32'd56);
    chk("ovr_stick", 32'(overrun), 32'd1);

    // reset while a fetch is outstanding, then a stray ack
    ack_delay = 1000;
    for (int i = 0; i < 8; i++) begin
      if (rom_req) break;
      do_tick();
    end
    chk("rf_req", 32'(rom_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rf_async", 32'(rom_req), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    man_ack = 1'b1;
    step(2);
    man_ack = 1'b0;
    chk("late_req", 32'(rom_req), 32'd0);
    chk("late_pos", 32'(songpos), 32'h1ff);
    chk("late_beat", 32'(beat_stb), 32'd0);
    chk("late_vol", 32'(mel_vol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
